dom_share_feeder: RTL and testbench

//   Input masking stage directly upstream of the first-order DOM AND gadget. Accepts two

---
 rtl/dom_share_feeder.sv | 176 +++++++++++++++++
 tb/tb_dom_share_feeder.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dom_share_feeder.sv
// Input masking stage feeding a first-order DOM AND gadget.
// Splits two unmasked operands into Boolean share pairs using fresh randomness
// from a Galois LFSR, and provides an extra resharing mask Z. The PRNG has to
// be seeded before any operand is accepted. After RESEED_INTERVAL transactions
// the PRNG must be reseeded. LFSR_W must be at least 3*DATA_W so that the
// m0/m1/z slices fit inside the state.
module dom_share_feeder #(
  parameter int                 DATA_W          = 8,
  parameter int                 LFSR_W          = 32,
  parameter logic [LFSR_W-1:0]  LFSR_TAPS       = LFSR_W'(32'h80200003),
  parameter int                 RESEED_INTERVAL = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // seed channel
  input  logic              seed_valid_i,
  output logic              seed_ready_o,
  input  logic [LFSR_W-1:0] seed_i,
  output logic              seed_err_o,
  output logic              reseed_req_o,
  // operand channel
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  // share bundle channel
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] X0_o,
  output logic [DATA_W-1:0] X1_o,
  output logic [DATA_W-1:0] Y0_o,
  output logic [DATA_W-1:0] Y1_o,
  output logic [DATA_W-1:0] Z_o
);

  // Each transaction consumes three DATA_W slices of PRNG state.
  localparam int STEPS = 3 * DATA_W;
  // A count of zero for RESEED_INTERVAL means "never exhaust". Keep the
  // counter at least one bit wide so the declarations stay legal.
  localparam int CNT_W = (RESEED_INTERVAL > 0) ? $clog2(RESEED_INTERVAL + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RESEED_INTERVAL);

  typedef enum logic [1:0] {
    ST_UNSEEDED  = 2'd0,
    ST_RUN       = 2'd1,
    ST_EXHAUSTED = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                out_valid_q, out_valid_d;
  logic                seed_err_q, seed_err_d;
  logic [DATA_W-1:0]   x0_q, x0_d;
  logic [DATA_W-1:0]   x1_q, x1_d;
  logic [DATA_W-1:0]   y0_q, y0_d;
  logic [DATA_W-1:0]   y1_q, y1_d;
  logic [DATA_W-1:0]   z_q, z_d;

  logic [LFSR_W-1:0]   lfsr_adv;
  logic [DATA_W-1:0]   m0, m1, zmask;
  logic                seed_acc;
  logic                seed_zero;
  logic                txn_acc;
  logic                drain;

  // Mask slices are taken from the PRNG state before it advances.
  assign m0    = lfsr_q[DATA_W-1:0];
  assign m1    = lfsr_q[2*DATA_W-1:DATA_W];
  assign zmask = lfsr_q[3*DATA_W-1:2*DATA_W];

  // Handshakes. A seed is only taken while the output slot is empty, so a
  // reseed never races with a bundle that is still waiting to be consumed.
  assign seed_ready_o = !out_valid_q;
  assign in_ready_o   = (state_q == ST_RUN) && (!out_valid_q || out_ready_i);
  assign reseed_req_o = (state_q != ST_RUN);
  assign seed_acc     = seed_valid_i && !out_valid_q;
  assign seed_zero    = (seed_i == '0);
  assign txn_acc      = in_valid_i && in_ready_o;
  assign drain        = out_valid_q && out_ready_i;

  // Galois right-shift LFSR unrolled for all steps of one transaction.
  always_comb begin
    logic [LFSR_W-1:0] s;
    s = lfsr_q;
    for (int i = 0; i < STEPS; i++) begin
      if (s[0]) s = (s >> 1) ^ LFSR_TAPS;
      else      s = s >> 1;
    end
    lfsr_adv = s;
  end

  // Next-state logic: transaction accept first, then a seed accept overrides
  // the PRNG and counter updates so a same-cycle reseed takes priority.
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    seed_err_d  = 1'b0;
    x0_d        = x0_q;
    x1_d        = x1_q;
    y0_d        = y0_q;
    y1_d        = y1_q;
    z_d         = z_q;

    if (drain) begin
      out_valid_d = 1'b0;
    end

    if (txn_acc) begin
      out_valid_d = 1'b1;
      x0_d        = a_i ^ m0;
      x1_d        = m0;
      y0_d        = b_i ^ m1;
      y1_d        = m1;
      z_d         = zmask;
      lfsr_d      = lfsr_adv;
      if (RESEED_INTERVAL != 0) begin
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (cnt_q + CNT_W'(1) == CNT_MAX) begin
          state_d = ST_EXHAUSTED;
        end
      end
    end

    if (seed_acc) begin
      if (seed_zero) begin
        // An all-zero seed would lock the LFSR; drop it and flag the error.
        seed_err_d = 1'b1;
      end else begin
        lfsr_d  = seed_i;
        cnt_d   = '0;
        state_d = ST_RUN;
      end
    end
  end

  // State, PRNG, counter and share registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_UNSEEDED;
      lfsr_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      seed_err_q  <= 1'b0;
      x0_q        <= '0;
      x1_q        <= '0;
      y0_q        <= '0;
      y1_q        <= '0;
      z_q         <= '0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      seed_err_q  <= seed_err_d;
      x0_q        <= x0_d;
      x1_q        <= x1_d;
      y0_q        <= y0_d;
      y1_q        <= y1_d;
      z_q         <= z_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign seed_err_o  = seed_err_q;
  assign X0_o        = x0_q;
  assign X1_o        = x1_q;
  assign Y0_o        = y0_q;
  assign Y1_o        = y1_q;
  assign Z_o         = z_q;

endmodule

// File: tb/tb_dom_share_feeder.sv
// Directed and constrained-random bench for dom_share_feeder. A second
// instance with a short reseed interval covers the exhaustion behaviour.
module tb_dom_share_feeder;

  localparam logic [31:0] TAPS = 32'h80200003;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic        seed_valid, seed_ready, seed_err, reseed_req;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] seed;
  logic [7:0]  a, b, x0, x1, y0, y1, z;

  // RESEED_INTERVAL = 4 instance
  logic        q_seed_valid, q_seed_ready, q_seed_err, q_reseed_req;
  logic        q_in_valid, q_in_ready, q_out_valid, q_out_ready;
  logic [31:0] q_seed;
  logic [7:0]  q_a, q_b, q_x0, q_x1, q_y0, q_y1, q_z;

  int total = 0;
  int bad   = 0;
  logic [31:0] model_lfsr;

  dom_share_feeder dut (
    .clk_i(clk), .rst_i(rst_n),
    .seed_valid_i(seed_valid), .seed_ready_o(seed_ready), .seed_i(seed),
    .seed_err_o(seed_err), .reseed_req_o(reseed_req),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .a_i(a), .b_i(b),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .X0_o(x0), .X1_o(x1), .Y0_o(y0), .Y1_o(y1), .Z_o(z)
  );

  dom_share_feeder #(.RESEED_INTERVAL(4)) dut4 (
    .clk_i(clk), .rst_i(rst_n),
    .seed_valid_i(q_seed_valid), .seed_ready_o(q_seed_ready), .seed_i(q_seed),
    .seed_err_o(q_seed_err), .reseed_req_o(q_reseed_req),
    .in_valid_i(q_in_valid), .in_ready_o(q_in_ready), .a_i(q_a), .b_i(q_b),
    .out_valid_o(q_out_valid), .out_ready_i(q_out_ready),
    .X0_o(q_x0), .X1_o(q_x1), .Y0_o(q_y0), .Y1_o(q_y1), .Z_o(q_z)
  );

  // Software reference for 24 Galois right-shift steps.
  function automatic logic [31:0] galois24(input logic [31:0] s_in);
    logic [31:0] s;
    logic        lsb;
    s = s_in;
    for (int i = 0; i < 24; i++) begin
      lsb = s[0];
      s   = s >> 1;
      if (lsb) s = s ^ TAPS;
    end
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    seed_valid = 0; seed = '0; in_valid = 0; a = '0; b = '0; out_ready = 0;
    q_seed_valid = 0; q_seed = '0; q_in_valid = 0; q_a = '0; q_b = '0; q_out_ready = 0;
    rst_n = 0;
    repeat (3) tick();
    total++;
    if ({out_valid, seed_err, x0, x1, y0, y1, z} !== 42'h0) begin
      bad++; $display("FAIL reset_outputs: got %h want 0", {out_valid, seed_err, x0, x1, y0, y1, z});
    end
    total++;
    if ({reseed_req, in_ready, seed_ready} !== 3'b101) begin
      bad++; $display("FAIL reset_flags: got %b want 101", {reseed_req, in_ready, seed_ready});
    end
    rst_n = 1;
    in_valid = 1; a = 8'h11; b = 8'h22;
    for (int i = 0; i < 20; i++) begin
      tick();
      total++;
      if ({in_ready, reseed_req, out_valid} !== 3'b010) begin
        bad++; $display("FAIL unseeded_block cyc %0d: got %b want 010", i, {in_ready, reseed_req, out_valid});
      end
    end
    in_valid = 0;
    $display("reset: unseeded operand offer held off for 20 cycles");
  endtask

  task automatic test_zero_seed();
    seed = 32'h0; seed_valid = 1;
    #1;
    total++;
    if (seed_ready !== 1'b1) begin
      bad++; $display("FAIL zero_seed_ready: got %b want 1", seed_ready);
    end
    tick();
    seed_valid = 0;
    total++;
    if ({seed_err, reseed_req, in_ready} !== 3'b110) begin
      bad++; $display("FAIL zero_seed_err: got %b want 110", {seed_err, reseed_req, in_ready});
    end
    tick();
    total++;
    if ({seed_err, reseed_req} !== 2'b01) begin
      bad++; $display("FAIL zero_seed_pulse: got %b want 01", {seed_err, reseed_req});
    end
    $display("seed 00000000: rejected, still unseeded");
  endtask

  task automatic test_first_bundle();
    seed = 32'hDEADBEEF; seed_valid = 1;
    tick();
    seed_valid = 0;
    model_lfsr = 32'hDEADBEEF;
    total++;
    if ({in_ready, reseed_req, seed_err} !== 3'b100) begin
      bad++; $display("FAIL seeded_flags: got %b want 100", {in_ready, reseed_req, seed_err});
    end
    a = 8'hA5; b = 8'h3C; in_valid = 1; out_ready = 0;
    tick();
    in_valid = 0;
    model_lfsr = galois24(model_lfsr);
    total++;
    if ({out_valid, x0, x1, y0, y1, z} !== {1'b1, 8'h4A, 8'hEF, 8'h82, 8'hBE, 8'hAD}) begin
      bad++; $display("FAIL first_bundle: got %h want 14aef82bead", {out_valid, x0, x1, y0, y1, z});
    end
    total++;
    if ({seed_ready, in_ready} !== 2'b00) begin
      bad++; $display("FAIL full_slot_ready: got %b want 00", {seed_ready, in_ready});
    end
    a = 8'h00; b = 8'hFF;
    repeat (3) tick();
    total++;
    if ({out_valid, x0, x1, y0, y1, z} !== {1'b1, 8'h4A, 8'hEF, 8'h82, 8'hBE, 8'hAD}) begin
      bad++; $display("FAIL first_bundle_hold: got %h want 14aef82bead", {out_valid, x0, x1, y0, y1, z});
    end
    out_ready = 1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL drain_in_ready: got %b want 1", in_ready);
    end
    tick();
    out_ready = 0;
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL drain_clear: got %b want 0", out_valid);
    end
    $display("txn a=a5 b=3c -> X0=4a X1=ef Y0=82 Y1=be Z=ad");
  endtask

  task automatic test_random();
    logic [39:0] expq[$];
    logic [39:0] snap, got, exp_b;
    logic        hold, exp_valid, acc, drn;
    int          sent, drained, cyc;
    hold = 0; exp_valid = 0; sent = 0; drained = 0; cyc = 0; snap = '0;
    while ((sent < 200 || expq.size() != 0) && cyc < 3000) begin
      in_valid  = (sent < 200) && ($urandom_range(0, 3) != 0);
      a         = 8'($urandom);
      b         = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      got = {x0, x1, y0, y1, z};
      total++;
      if (out_valid !== exp_valid) begin
        bad++; $display("FAIL rnd_valid cyc %0d: got %b want %b", cyc, out_valid, exp_valid);
      end
      total++;
      if (in_ready !== (!exp_valid || out_ready)) begin
        bad++; $display("FAIL rnd_in_ready cyc %0d: got %b want %b", cyc, in_ready, (!exp_valid || out_ready));
      end
      if (hold) begin
        total++;
        if (got !== snap) begin
          bad++; $display("FAIL rnd_hold cyc %0d: got %h want %h", cyc, got, snap);
        end
      end
      acc = in_valid && in_ready;
      drn = out_valid && out_ready;
      if (drn) begin
        total++;
        if (expq.size() == 0) begin
          bad++; $display("FAIL rnd_dup cyc %0d: got bundle %h want none", cyc, got);
        end else begin
          exp_b = expq.pop_front();
          if (got !== exp_b) begin
            bad++; $display("FAIL rnd_bundle %0d: got %h want %h", drained, got, exp_b);
          end
          $display("rnd bundle %0d: %h", drained, got);
        end
        drained++;
      end
      if (acc) begin
        expq.push_back({a ^ model_lfsr[7:0], model_lfsr[7:0],
                        b ^ model_lfsr[15:8], model_lfsr[15:8], model_lfsr[23:16]});
        model_lfsr = galois24(model_lfsr);
        sent++;
      end
      exp_valid = acc ? 1'b1 : (drn ? 1'b0 : exp_valid);
      hold = out_valid && !out_ready;
      snap = got;
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 0; out_ready = 0;
    total++;
    if (sent != 200 || drained != 200) begin
      bad++; $display("FAIL rnd_complete: got sent=%0d drained=%0d want 200/200", sent, drained);
    end
  endtask

  task automatic test_back_to_back();
    logic [39:0] exp_b;
    a = 8'h11; b = 8'h22; in_valid = 1; out_ready = 1;
    seed = 32'h12345678; seed_valid = 1;
    #1;
    total++;
    if ({in_ready, seed_ready} !== 2'b11) begin
      bad++; $display("FAIL same_cycle_ready: got %b want 11", {in_ready, seed_ready});
    end
    exp_b = {8'h11 ^ model_lfsr[7:0], model_lfsr[7:0], 8'h22 ^ model_lfsr[15:8],
             model_lfsr[15:8], model_lfsr[23:16]};
    tick();
    seed_valid = 0;
    model_lfsr = 32'h12345678;
    total++;
    if ({x0, x1, y0, y1, z} !== exp_b) begin
      bad++; $display("FAIL same_cycle_old_lfsr: got %h want %h", {x0, x1, y0, y1, z}, exp_b);
    end
    $display("txn a=11 b=22 with seed 12345678: %h", {x0, x1, y0, y1, z});
    a = 8'hFF; b = 8'h00;
    tick();
    in_valid = 0;
    total++;
    if ({out_valid, x0, x1, y0, y1, z} !== {1'b1, 8'h87, 8'h78, 8'h56, 8'h56, 8'h34}) begin
      bad++; $display("FAIL after_seed_bundle: got %h want 1877856 5634", {out_valid, x0, x1, y0, y1, z});
    end
    $display("txn a=ff b=00 -> %h", {x0, x1, y0, y1, z});
    tick();
    out_ready = 0;
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_drain: got %b want 0", out_valid);
    end
  endtask

  task automatic test_interval4();
    q_out_ready = 1;
    q_seed = 32'hDEADBEEF; q_seed_valid = 1;
    tick();
    q_seed_valid = 0;
    q_in_valid = 1; q_a = 8'h01; q_b = 8'h02;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (q_in_ready !== 1'b1) begin
        bad++; $display("FAIL i4_accept %0d: got %b want 1", i, q_in_ready);
      end
      tick();
    end
    q_in_valid = 0;
    total++;
    if ({q_in_ready, q_reseed_req, q_out_valid} !== 3'b011) begin
      bad++; $display("FAIL i4_exhausted: got %b want 011", {q_in_ready, q_reseed_req, q_out_valid});
    end
    tick();
    total++;
    if ({q_out_valid, q_in_ready} !== 2'b00) begin
      bad++; $display("FAIL i4_drained: got %b want 00", {q_out_valid, q_in_ready});
    end
    q_seed = 32'h12345678; q_seed_valid = 1;
    tick();
    q_seed_valid = 0;
    total++;
    if ({q_in_ready, q_reseed_req} !== 2'b10) begin
      bad++; $display("FAIL i4_reseeded: got %b want 10", {q_in_ready, q_reseed_req});
    end
    q_in_valid = 1; q_a = 8'h00; q_b = 8'h00;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (q_in_ready !== 1'b1) begin
        bad++; $display("FAIL i4_second_accept %0d: got %b want 1", i, q_in_ready);
      end
      tick();
      if (i == 0) begin
        total++;
        if ({q_x0, q_x1, q_y0, q_y1, q_z} !== {8'h78, 8'h78, 8'h56, 8'h56, 8'h34}) begin
          bad++; $display("FAIL i4_seed_masks: got %h want 7878565634", {q_x0, q_x1, q_y0, q_y1, q_z});
        end
      end
    end
    q_in_valid = 0;
    total++;
    if ({q_in_ready, q_reseed_req} !== 2'b01) begin
      bad++; $display("FAIL i4_exhausted2: got %b want 01", {q_in_ready, q_reseed_req});
    end
    $display("interval4: 4 accepts, reseed, 4 accepts");
    // Reseed, take two, then reseed together with a transaction: the counter
    // must restart from zero, leaving four further accepts.
    tick();
    q_seed = 32'hCAFEF00D; q_seed_valid = 1;
    tick();
    q_seed_valid = 0;
    q_in_valid = 1;
    repeat (2) tick();
    q_in_valid = 0;
    tick();
    q_in_valid = 1; q_seed = 32'h0BADF00D; q_seed_valid = 1;
    #1;
    total++;
    if ({q_in_ready, q_seed_ready} !== 2'b11) begin
      bad++; $display("FAIL i4_same_cycle_ready: got %b want 11", {q_in_ready, q_seed_ready});
    end
    tick();
    q_seed_valid = 0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (q_in_ready !== 1'b1) begin
        bad++; $display("FAIL i4_count_cleared %0d: got %b want 1", i, q_in_ready);
      end
      tick();
    end
    q_in_valid = 0;
    total++;
    if (q_in_ready !== 1'b0) begin
      bad++; $display("FAIL i4_exhausted3: got %b want 0", q_in_ready);
    end
    $display("interval4: same-cycle seed cleared count to 0");
  endtask

  initial begin
    test_reset();
    test_zero_seed();
    test_first_bundle();
    test_random();
    test_back_to_back();
    test_interval4();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
